// File: rtl/button_scan_ctrl.sv
// Scans a 16-bit parallel-in serial-out button shift register, debounces each
// button and reports presses as one-cycle strobes.
module button_scan_ctrl #(
  parameter int unsigned CLK_DIV        = 2,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter int unsigned GAP_CYCLES     = 16
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        enable,
  input  logic        shiftreg_out,
  output logic        shiftreg_clk,
  output logic        shiftreg_loadn,
  output logic [15:0] buttons,
  output logic [15:0] press_pulse,
  output logic        scan_done
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT_LO,
    SHIFT_HI,
    UPDATE,
    GAP
  } state_e;

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
  localparam logic [3:0]  DEB_MAX  = 4'(DEBOUNCE_SCANS);

  state_e           state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [3:0]       bit_q, bit_d;
  logic [15:0]      raw_q, raw_d;
  logic [15:0]      btn_q, btn_d;
  logic [15:0]      pulse_q, pulse_d;
  logic             done_q, done_d;
  logic             sclk_q, sclk_d;
  logic             loadn_q, loadn_d;
  logic [15:0][3:0] deb_q, deb_d;
  logic             div_last;

  assign div_last = (cnt_q == DIV_LAST);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      raw_q   <= '0;
      btn_q   <= '0;
      pulse_q <= '0;
      done_q  <= 1'b0;
      sclk_q  <= 1'b0;
      loadn_q <= 1'b1;
      deb_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      raw_q   <= raw_d;
      btn_q   <= btn_d;
      pulse_q <= pulse_d;
      done_q  <= done_d;
      sclk_q  <= sclk_d;
      loadn_q <= loadn_d;
      deb_q   <= deb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    bit_d   = bit_q;
    raw_d   = raw_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (enable) state_d = LOAD;
      end
      LOAD: begin
        if (div_last) begin
          state_d = SHIFT_LO;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
      SHIFT_LO: begin
        // First sample ends up in bit 15 after all 16 shifts.
        if (div_last) begin
          raw_d   = {raw_q[14:0], ~shiftreg_out};
          state_d = SHIFT_HI;
          cnt_d   = '0;
        end
      end
      SHIFT_HI: begin
        if (div_last) begin
          cnt_d = '0;
          if (bit_q == 4'd15) begin
            state_d = UPDATE;
          end else begin
            bit_d   = bit_q + 4'd1;
            state_d = SHIFT_LO;
          end
        end
      end
      UPDATE: begin
        state_d = GAP;
        cnt_d   = '0;
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = enable ? LOAD : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Pin outputs are decoded from the next state so they leave flops in step with it.
  always_comb begin
    loadn_d = (state_d != LOAD);
    sclk_d  = (state_d == SHIFT_HI);
    done_d  = (state_q == UPDATE);
    btn_d   = btn_q;
    deb_d   = deb_q;
    pulse_d = '0;
    if (state_q == UPDATE) begin
      for (int unsigned i = 0; i < 16; i++) begin
        if (raw_q[i] != btn_q[i]) begin
          if (4'(deb_q[i] + 4'd1) == DEB_MAX) begin
            btn_d[i] = ~btn_q[i];
            deb_d[i] = '0;
          end else begin
            deb_d[i] = deb_q[i] + 4'd1;
          end
        end else begin
          deb_d[i] = '0;
        end
      end
      pulse_d = btn_d & ~btn_q;
    end
  end

  assign shiftreg_clk   = sclk_q;
  assign shiftreg_loadn = loadn_q;
  assign buttons        = btn_q;
  assign press_pulse    = pulse_q;
  assign scan_done      = done_q;

endmodule

// File: tb/tb_button_scan_ctrl.sv
// Directed bench for button_scan_ctrl: an external shift-register model plus
// per-scan expected debounce results and hand sequences for timing/enable/reset.
module tb_button_scan_ctrl;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n;
  logic        enable;
  logic        shiftreg_out;
  logic        shiftreg_clk;
  logic        shiftreg_loadn;
  logic [15:0] buttons;
  logic [15:0] press_pulse;
  logic        scan_done;

  logic [15:0] pat = 16'hFFFF;
  logic [15:0] sr  = 16'hFFFF;
  int          checks = 0;
  int          fails = 0;
  int          cyc = 0;
  int          stray_pulses = 0;

  typedef struct {
    logic [15:0] pat;
    logic [15:0] exp_btn;
    logic [15:0] exp_pulse;
  } vec_t;

  vec_t vecs[23];

  always #5 clk_clk = ~clk_clk;

  button_scan_ctrl #(
    .CLK_DIV(2),
    .DEBOUNCE_SCANS(4),
    .GAP_CYCLES(16)
  ) dut (
    .clk_clk(clk_clk),
    .reset_reset_n(reset_reset_n),
    .enable(enable),
    .shiftreg_out(shiftreg_out),
    .shiftreg_clk(shiftreg_clk),
    .shiftreg_loadn(shiftreg_loadn),
    .buttons(buttons),
    .press_pulse(press_pulse),
    .scan_done(scan_done)
  );

  // External 74HC165-style register: MSB first, ones shifted in behind.
  always @(posedge shiftreg_clk or negedge shiftreg_loadn) begin
    if (!shiftreg_loadn) sr <= pat;
    else                 sr <= {sr[14:0], 1'b1};
  end
  assign shiftreg_out = sr[15];

  always @(posedge clk_clk) cyc <= cyc + 1;

  always @(negedge clk_clk) begin
    if (reset_reset_n === 1'b1 && press_pulse != 16'h0 && !scan_done)
      stray_pulses <= stray_pulses + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_scan_done(input string name);
    int n = 0;
    @(negedge clk_clk);
    while (!scan_done && n < 300) begin
      @(negedge clk_clk);
      n++;
    end
    check(name, 64'(scan_done), 64'd1);
  endtask

  // Returns at the first negedge where shift clock pulse number k (0-based) is high.
  task automatic wait_bit(input string name, input int k);
    int n = 0;
    int rises = 0;
    logic prev = 1'b0;
    while (shiftreg_loadn && n < 300) begin
      @(negedge clk_clk);
      n++;
    end
    n = 0;
    while (rises < k + 1 && n < 300) begin
      @(negedge clk_clk);
      if (shiftreg_clk && !prev) rises++;
      prev = shiftreg_clk;
      n++;
    end
    check(name, 64'(rises), 64'(k + 1));
  endtask

  function automatic logic [63:0] pins();
    return {29'h0, shiftreg_loadn, shiftreg_clk, scan_done, buttons, press_pulse};
  endfunction

  localparam logic [63:0] PINS_RESET = {29'h0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0};

  initial begin
    int lo, hi, n, t1, t2, dones, lows;
    logic sclk_seen;

    for (int i = 0; i < 3; i++)  vecs[i] = '{16'hFFFE, 16'h0000, 16'h0000};
    vecs[3] = '{16'hFFFE, 16'h0001, 16'h0001};
    for (int i = 4; i < 7; i++)  vecs[i] = '{16'hFFFF, 16'h0001, 16'h0000};
    vecs[7]  = '{16'hFFFF, 16'h0000, 16'h0000};
    vecs[8]  = '{16'h7FFF, 16'h0000, 16'h0000};
    vecs[9]  = '{16'h7FFF, 16'h0000, 16'h0000};
    vecs[10] = '{16'hFFFF, 16'h0000, 16'h0000};
    for (int i = 11; i < 14; i++) vecs[i] = '{16'h7FFF, 16'h0000, 16'h0000};
    vecs[14] = '{16'h7FFF, 16'h8000, 16'h8000};
    for (int i = 15; i < 18; i++) vecs[i] = '{16'h5A3C, 16'h8000, 16'h0000};
    vecs[18] = '{16'h5A3C, 16'hA5C3, 16'h25C3};
    for (int i = 19; i < 22; i++) vecs[i] = '{16'hFFFF, 16'hA5C3, 16'h0000};
    vecs[22] = '{16'hFFFF, 16'h0000, 16'h0000};

    enable = 1'b0;
    reset_reset_n = 1'b1;
    #1 reset_reset_n = 1'b0;
    repeat (3) @(negedge clk_clk);
    check("reset_state", pins(), PINS_RESET);
    reset_reset_n = 1'b1;
    repeat (5) @(negedge clk_clk);
    check("idle_no_enable", pins(), PINS_RESET);

    // Scan timing at defaults.
    enable = 1'b1;
    n = 0;
    while (shiftreg_loadn && n < 10) begin
      @(negedge clk_clk);
      n++;
    end
    lo = 0;
    while (!shiftreg_loadn && lo < 10) begin
      lo++;
      @(negedge clk_clk);
    end
    check("loadn_low_cycles", 64'(lo), 64'd2);
    for (int b = 0; b < 16; b++) begin
      lo = 0;
      while (!shiftreg_clk && lo < 10) begin
        lo++;
        @(negedge clk_clk);
      end
      hi = 0;
      while (shiftreg_clk && hi < 10) begin
        hi++;
        @(negedge clk_clk);
      end
      check($sformatf("sclk_low_bit%0d", b), 64'(lo), 64'd2);
      check($sformatf("sclk_high_bit%0d", b), 64'(hi), 64'd2);
    end
    @(negedge clk_clk);
    check("scan_done_after_update", 64'(scan_done), 64'd1);
    t1 = cyc;
    wait_scan_done("scan_done_second");
    t2 = cyc;
    check("scan_period", 64'(t2 - t1), 64'd83);

    // Debounce table: one entry per scan.
    for (int i = 0; i < 23; i++) begin
      pat = vecs[i].pat;
      wait_scan_done($sformatf("vec%0d_scan_done", i));
      check($sformatf("vec%0d_buttons", i), 64'(buttons), 64'(vecs[i].exp_btn));
      check($sformatf("vec%0d_press_pulse", i), 64'(press_pulse), 64'(vecs[i].exp_pulse));
      @(negedge clk_clk);
      check($sformatf("vec%0d_strobes_clear", i), {47'h0, scan_done, press_pulse}, 64'h0);
    end

    // Enable drops at bit 5: the scan completes once, then the FSM parks in IDLE.
    pat = 16'hFFFF;
    wait_bit("enable_drop_bit5", 5);
    enable = 1'b0;
    dones = 0;
    lows = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk_clk);
      if (scan_done) dones++;
      if (!shiftreg_loadn) lows++;
    end
    check("enable_drop_scan_done_count", 64'(dones), 64'd1);
    check("enable_drop_no_reload", 64'(lows), 64'd0);
    check("enable_drop_idle_pins", pins(), PINS_RESET);

    // Build pressed state and partial counters, then reset mid-scan at bit 8.
    pat = 16'h0000;
    enable = 1'b1;
    for (int s = 0; s < 4; s++) wait_scan_done("press_all_scan");
    check("press_all_buttons", 64'(buttons), 64'hFFFF);
    check("press_all_pulse", 64'(press_pulse), 64'hFFFF);
    pat = 16'hFFFF;
    for (int s = 0; s < 2; s++) wait_scan_done("release_partial_scan");
    check("release_partial_buttons", 64'(buttons), 64'hFFFF);
    wait_bit("reset_at_bit8", 8);
    check("sclk_high_before_reset", 64'(shiftreg_clk), 64'd1);
    #2 reset_reset_n = 1'b0;
    #1 check("async_reset_pins", pins(), PINS_RESET);
    enable = 1'b0;
    sclk_seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_clk);
      sclk_seen |= shiftreg_clk;
    end
    check("no_sclk_in_reset", 64'(sclk_seen), 64'd0);
    reset_reset_n = 1'b1;
    dones = 0;
    lows = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_clk);
      if (scan_done) dones++;
      if (!shiftreg_loadn) lows++;
    end
    check("post_reset_no_scan_done", 64'(dones), 64'd0);
    check("post_reset_idle", 64'(lows), 64'd0);
    check("post_reset_buttons", 64'(buttons), 64'h0);

    // Debounce counters must restart from zero after reset.
    pat = 16'h0000;
    enable = 1'b1;
    for (int s = 0; s < 3; s++) begin
      wait_scan_done("post_reset_scan");
      check($sformatf("post_reset_scan%0d_buttons", s), 64'(buttons), 64'h0);
    end
    wait_scan_done("post_reset_scan4");
    check("post_reset_scan4_buttons", 64'(buttons), 64'hFFFF);
    check("post_reset_scan4_pulse", 64'(press_pulse), 64'hFFFF);

    check("stray_press_pulses", 64'(stray_pulses), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
